mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
Iterative multiply/divide unit providing the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU in the datapath and is driven by the controller. The controller stalls dependent MFHI/MFLO while busy=1. It is parametrised in operand width and adds stall/flush behaviour that the single-cycle core lacks.

Parameters:
WIDTH, 32, operand width in bits. HI and LO are each WIDTH wide. Must be ≥4 and even.
CNT_W, $clog2(WIDTH+1), iteration counter width. Derived; not overridden.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
start  in  1  request to begin op; sampled only when busy=0
op  in  3  operation code (encodings in mdu_pkg)
a  in  WIDTH  rs operand / dividend / MTHI-MTLO data
b  in  WIDTH  rt operand / divisor
flush  in  1  abort the in-flight op (exception/branch squash)
busy  out  1  multiply/divide iteration in progress
done  out  1  one-cycle pulse when HI/LO are written by mult/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, active-high): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-operation discards the op.
- FSM states:
  - IDLE: waiting for a request.
  - RUN: WIDTH iteration cycles.
  - FIX: sign correction and HI/LO writeback.
- IDLE to RUN: edge where start=1, busy=0, flush=0, and op ∈ {MULT, MULTU, DIV, DIVU}.
  - On that edge, latch operand magnitudes. Signed ops take |a| and |b|; unsigned ops take the raw values.
  - Latch the sign flags and clear the counter.
  - busy=1 from that edge onward.
- MTHI/MTLO in IDLE: written on the start edge. No busy, no done. hi (or lo) = a next cycle.
- start while busy=1 is ignored; no queueing.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 2·WIDTH product.
  - Divide: restoring step producing one quotient bit per cycle.
  - After WIDTH steps, go to FIX.
- FIX (1 cycle):
  - Product is negated if the signed op had operand signs that differ.
  - Quotient is negated if the divide signs differ.
  - Remainder takes the sign of the dividend.
  - hi = upper product or remainder; lo = lower product or quotient.
  - Next edge: busy=0, done=1 for exactly one cycle, FSM=IDLE.
- Latency: start edge E0 to HI/LO valid after edge E(WIDTH+1). busy is high for WIDTH+1 cycles. For WIDTH=32: 33 busy cycles.
- Back-to-back: start is accepted in the cycle done=1, since busy=0 there.
- Divide by zero (b==0, signed or unsigned): lo = all ones, hi = a (raw input value). Still full latency.
- Signed overflow (a = most-negative value, b = −1): lo = a, hi = 0.
- flush:
  - In RUN or FIX: on the next edge, FSM=IDLE, busy=0, done=0, hi/lo unchanged.
  - flush together with start in IDLE: start is ignored.
  - flush in IDLE with no start: no effect.
- Precedence: reset > flush > start.
- Undefined op codes with start=1: ignored; state unchanged.
- Width rules: internal product is 2·WIDTH bits. Divider partial remainder is WIDTH+1 bits. Counter is CNT_W bits and saturates at WIDTH.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5
  - FSM state typedef: IDLE, RUN, FIX
- One natural sub-module: mdu_step (combinational).
  - Given partial accumulator, operand and mode, returns the next accumulator.
  - Covers one multiply add-shift or one restoring divide step.
  - The top holds the FSM, counter, sign fix and HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFE, b=3 → after 33 busy cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF then MTLO a=0x5 on consecutive cycles → hi=0xDEADBEEF, lo=5; busy and done stay 0.
- Sequence:
  - Preload hi=1, lo=2.
  - Start MULT 7×9; assert flush at cycle 10 → busy=0 next cycle, no done, hi=1, lo=2 unchanged.
  - Repeat, but assert reset mid-RUN instead → hi=lo=0 immediately.
- start pulsed during busy, then again in the done cycle → first ignored; second accepted with busy continuous. Verify with WIDTH=8 and WIDTH=32 builds.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and small op-classification helpers.
package mdu_pkg;

   // Operation encodings driven by the controller on op.
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // Sequencer states: waiting, iterating, sign fix + writeback.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // True for the operations that need the multi-cycle datapath.
   function automatic logic is_iter_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // True for the two's-complement variants (operands taken by magnitude).
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   // True for the divide variants.
   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the shared multiply/divide accumulator.
// The accumulator is {upper[WIDTH:0], lower[WIDTH-1:0]}:
//   multiply: upper = running partial product, lower = remaining multiplier bits
//   divide:   upper = partial remainder,       lower = dividend bits / quotient
module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0] acc,
   input  logic [WIDTH-1:0] operand,
   input  logic             div,
   output logic [2*WIDTH:0] acc_next
);

   logic [WIDTH:0]   upper;
   logic [WIDTH-1:0] lower;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl_rem;
   logic [WIDTH+1:0] diff;

   assign upper = acc[2*WIDTH:WIDTH];
   assign lower = acc[WIDTH-1:0];

   // Shift-add for multiply, shift-subtract-restore for divide.
   always_comb begin
      // NOTE: every variable gets a default first so no path can leave it
      // unassigned; a missed branch would otherwise infer a latch.
      acc_next = acc;
      sum      = '0;
      shl_rem  = '0;
      diff     = '0;
      if (!div) begin
         // Add the multiplicand when the current multiplier bit is set,
         // then shift the whole accumulator right by one.
         sum      = lower[0] ? (upper + {1'b0, operand}) : upper;
         acc_next = {1'b0, sum, lower[WIDTH-1:1]};
      end else begin
         // Bring the next dividend bit into the remainder and try a subtract;
         // keep the difference only if it did not borrow.
         shl_rem = {upper[WIDTH-1:0], lower[WIDTH-1]};
         diff    = {1'b0, shl_rem} - {2'b00, operand};
         if (diff[WIDTH+1]) begin
            acc_next = {shl_rem, lower[WIDTH-2:0], 1'b0};
         end else begin
            acc_next = {diff[WIDTH:0], lower[WIDTH-2:0], 1'b1};
         end
      end
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Operands are latched as magnitudes, WIDTH radix-2 steps run in RUN, and
// FIX applies the sign correction and writes HI/LO. busy covers RUN and FIX.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t state, state_next;

   logic [CNT_W-1:0] cnt;
   logic [2*WIDTH:0] acc;
   logic [2*WIDTH:0] acc_next;
   logic [WIDTH-1:0] opnd;
   logic             is_div;
   logic             neg_res;
   logic             neg_rem;
   logic             div0;

   // Control strobes from the sequencer.
   logic accept;
   logic step_en;
   logic wb_en;
   logic wr_hi;
   logic wr_lo;
   logic done_next;

   // Operand preparation.
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   // Sign-corrected results.
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   hi_res;
   logic [WIDTH-1:0]   lo_res;

   assign a_neg = is_signed_op(op) & a[WIDTH-1];
   assign b_neg = is_signed_op(op) & b[WIDTH-1];
   assign a_mag = a_neg ? (~a + 1'b1) : a;
   assign b_mag = b_neg ? (~b + 1'b1) : b;

   assign busy = (state != IDLE);

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .operand  (opnd),
      .div      (is_div),
      .acc_next (acc_next)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and strobe decode; flush outranks start and writeback.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      step_en    = 1'b0;
      wb_en      = 1'b0;
      wr_hi      = 1'b0;
      wr_lo      = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !flush) begin
               if (is_iter_op(op)) begin
                  accept     = 1'b1;
                  state_next = RUN;
               end else if (op == OP_MTHI) begin
                  wr_hi = 1'b1;
               end else if (op == OP_MTLO) begin
                  wr_lo = 1'b1;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               step_en = 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state_next = FIX;
               end
            end
         end
         FIX: begin
            state_next = IDLE;
            if (!flush) begin
               wb_en     = 1'b1;
               done_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture on accept, then one accumulator step per RUN cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         opnd    <= '0;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         div0    <= 1'b0;
      end else if (accept) begin
         acc     <= {{(WIDTH + 1){1'b0}}, a_mag};
         opnd    <= b_mag;
         cnt     <= '0;
         is_div  <= is_div_op(op);
         neg_res <= a_neg ^ b_neg;
         neg_rem <= a_neg;
         div0    <= (b == '0);
      end else if (step_en) begin
         acc <= acc_next;
         if (cnt != CNT_W'(WIDTH)) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Sign correction. A zero divisor leaves the remainder equal to |a|, which
   // the dividend-sign fix turns back into a, so only LO needs overriding.
   assign prod     = acc[2*WIDTH-1:0];
   assign prod_fix = neg_res ? (~prod + 1'b1) : prod;
   assign quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
   assign rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
   assign hi_res   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
   assign lo_res   = is_div ? (div0 ? '1 : quo_fix) : prod_fix[WIDTH-1:0];

   // HI/LO registers: writeback from FIX or direct MTHI/MTLO moves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (wb_en) begin
         hi <= hi_res;
         lo <= lo_res;
      end else begin
         if (wr_hi) hi <= a;
         if (wr_lo) lo <= a;
      end
   end

   // Single-cycle completion pulse following the FIX writeback.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done <= 1'b0;
      end else begin
         done <= done_next;
      end
   end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: a 32-bit instance for the bulk of the
// directed and random tests plus an 8-bit instance for back-to-back and
// random coverage at a small width. Expected HI/LO come from plain integer
// arithmetic on sign-extended 64-bit values.
module tb_mdu_iter;
   import mdu_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        start32;
   logic        start8;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;

   logic        busy32, done32, busy8, done8;
   logic [31:0] hi32, lo32;
   logic [7:0]  hi8, lo8;

   logic        sel;   // 0: 32-bit instance, 1: 8-bit instance
   logic        busy_s, done_s;
   logic [31:0] hi_s, lo_s;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mdu_iter #(.WIDTH(32)) dut32 (
      .clk   (clk),
      .reset (reset),
      .start (start32),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy32),
      .done  (done32),
      .hi    (hi32),
      .lo    (lo32)
   );

   mdu_iter #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .start (start8),
      .op    (op),
      .a     (a[7:0]),
      .b     (b[7:0]),
      .flush (flush),
      .busy  (busy8),
      .done  (done8),
      .hi    (hi8),
      .lo    (lo8)
   );

   assign busy_s = sel ? busy8 : busy32;
   assign done_s = sel ? done8 : done32;
   assign hi_s   = sel ? {24'b0, hi8} : hi32;
   assign lo_s   = sel ? {24'b0, lo8} : lo32;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: HI/LO for an n-bit MULT/MULTU/DIV/DIVU from integer arithmetic.
   function automatic res_t model(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y, input int n);
      logic [63:0] mask, ux, uy, p, t;
      longint      sx, sy;
      res_t        r;
      mask = (64'd1 << n) - 64'd1;
      ux   = {32'b0, x} & mask;
      uy   = {32'b0, y} & mask;
      sx   = ux[n-1] ? $signed(ux | ~mask) : $signed(ux);
      sy   = uy[n-1] ? $signed(uy | ~mask) : $signed(uy);
      r.hi = '0;
      r.lo = '0;
      case (o)
         OP_MULT, OP_MULTU: begin
            p    = (o == OP_MULT) ? 64'(sx * sy) : ux * uy;
            t    = (p >> n) & mask;
            r.hi = t[31:0];
            t    = p & mask;
            r.lo = t[31:0];
         end
         default: begin
            if (uy == 64'd0) begin
               r.hi = ux[31:0];
               r.lo = mask[31:0];
            end else begin
               t    = (o == OP_DIV) ? 64'(sx % sy) : ux % uy;
               t    = t & mask;
               r.hi = t[31:0];
               t    = (o == OP_DIV) ? 64'(sx / sy) : ux / uy;
               t    = t & mask;
               r.lo = t[31:0];
            end
         end
      endcase
      return r;
   endfunction

   // Random operand biased toward the interesting corners of an n-bit word.
   function automatic logic [31:0] pick(input int n);
      logic [31:0] m;
      m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return m;
         3:       return 32'd1 << (n - 1);
         default: return $urandom & m;
      endcase
   endfunction

   task automatic drive_start(input logic v);
      if (sel) start8 = v;
      else     start32 = v;
   endtask

   // Count negedges with busy high, bounded so a stuck DUT cannot hang the run.
   task automatic wait_busy(output int cyc);
      cyc = 0;
      while (busy_s && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y);
      res_t e;
      int   n, cyc;
      n = sel ? 8 : 32;
      e = model(o, x, y, n);
      @(negedge clk);
      op = o; a = x; b = y;
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      wait_busy(cyc);
      check({tag, " busy_cycles"}, 32'(cyc), 32'(n + 1));
      check({tag, " done"}, 32'(done_s), 32'd1);
      check({tag, " hi"}, hi_s, e.hi);
      check({tag, " lo"}, lo_s, e.lo);
      @(negedge clk);
      check({tag, " done_pulse"}, 32'(done_s), 32'd0);
   endtask

   task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
      @(negedge clk);
      op = OP_MTHI; a = h; drive_start(1'b1);
      @(negedge clk);
      op = OP_MTLO; a = l;
      @(negedge clk);
      drive_start(1'b0);
   endtask

   // Start ignored while busy, then a new op accepted in the done cycle.
   task automatic back_to_back(input string tag,
                               input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                               input logic [2:0] o2, input logic [31:0] x2, input logic [31:0] y2);
      res_t e1, e2;
      int   n, cyc;
      n  = sel ? 8 : 32;
      e1 = model(o1, x1, y1, n);
      e2 = model(o2, x2, y2, n);
      @(negedge clk);
      op = o1; a = x1; b = y1;
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      repeat (2) @(negedge clk);
      op = OP_DIVU; a = ~x1; b = 32'd3;
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      wait_busy(cyc);
      check({tag, " first_done"}, 32'(done_s), 32'd1);
      check({tag, " first_hi"}, hi_s, e1.hi);
      check({tag, " first_lo"}, lo_s, e1.lo);
      op = o2; a = x2; b = y2;
      drive_start(1'b1);
      @(negedge clk);
      drive_start(1'b0);
      check({tag, " restart_busy"}, 32'(busy_s), 32'd1);
      wait_busy(cyc);
      check({tag, " second_busy_cycles"}, 32'(cyc), 32'(n + 1));
      check({tag, " second_hi"}, hi_s, e2.hi);
      check({tag, " second_lo"}, lo_s, e2.lo);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      sel = 1'b0; reset = 1'b1; flush = 1'b0;
      start32 = 1'b0; start8 = 1'b0;
      op = '0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset hi", hi32, 32'd0);
      check("reset lo", lo32, 32'd0);
      check("reset busy", 32'(busy32), 32'd0);
      check("reset done", 32'(done32), 32'd0);
      reset = 1'b0;

      // Directed arithmetic cases, 32-bit.
      run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3);
      run_op("multu",      OP_MULTU, 32'hFFFF_FFFE, 32'd3);
      run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2);
      run_op("divu",       OP_DIVU,  32'd100,       32'd7);
      run_op("divu_zero",  OP_DIVU,  32'h0000_1234, 32'd0);
      run_op("div_zero",   OP_DIV,   32'hFFFF_FF00, 32'd0);
      run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run_op("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000);

      // MTHI then MTLO on consecutive cycles.
      @(negedge clk);
      op = OP_MTHI; a = 32'hDEAD_BEEF; start32 = 1'b1;
      @(negedge clk);
      check("mthi hi", hi32, 32'hDEAD_BEEF);
      check("mthi busy", 32'(busy32), 32'd0);
      op = OP_MTLO; a = 32'd5;
      @(negedge clk);
      start32 = 1'b0;
      check("mtlo lo", lo32, 32'd5);
      check("mtlo hi", hi32, 32'hDEAD_BEEF);
      check("mtlo busy", 32'(busy32), 32'd0);
      check("mtlo done", 32'(done32), 32'd0);

      // Flush mid-RUN leaves HI/LO untouched and produces no done.
      write_hilo(32'd1, 32'd2);
      @(negedge clk);
      op = OP_MULT; a = 32'd7; b = 32'd9; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 32'(busy32), 32'd0);
      check("flush done", 32'(done32), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy32 || done32) seen++;
      end
      check("flush quiet", 32'(seen), 32'd0);
      check("flush hi", hi32, 32'd1);
      check("flush lo", lo32, 32'd2);

      // Flush together with start in IDLE, MTHI under flush, undefined ops.
      flush = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3; start32 = 1'b1;
      @(negedge clk);
      check("flush_start busy", 32'(busy32), 32'd0);
      op = OP_MTHI; a = 32'h5555_5555;
      @(negedge clk);
      flush = 1'b0;
      check("flush_mthi hi", hi32, 32'd1);
      op = 3'd6;
      @(negedge clk);
      op = 3'd7;
      @(negedge clk);
      start32 = 1'b0;
      check("undef busy", 32'(busy32), 32'd0);
      check("undef hi", hi32, 32'd1);
      check("undef lo", lo32, 32'd2);

      // Asynchronous reset mid-RUN clears HI/LO immediately.
      write_hilo(32'h11, 32'h22);
      @(negedge clk);
      op = OP_MULT; a = 32'd7; b = 32'd9; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset hi", hi32, 32'd0);
      check("midreset lo", lo32, 32'd0);
      check("midreset busy", 32'(busy32), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("after_reset", OP_MULT, 32'd7, 32'd9);

      back_to_back("b2b32", OP_DIV, 32'hFFFF_FF9C, 32'd7, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("rand32_%0d", i), 3'($urandom_range(0, 3)), pick(32), pick(32));
      end

      // 8-bit instance.
      sel = 1'b1;
      back_to_back("b2b8", OP_MULT, 32'h0000_00FE, 32'h0000_0003, OP_DIV, 32'h0000_0080, 32'h0000_00FF);
      run_op("div8_zero", OP_DIV, 32'h0000_00F0, 32'd0);
      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("rand8_%0d", i), 3'($urandom_range(0, 3)), pick(8), pick(8));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
